// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: owns the machine timer, latches external interrupt
// lines, resolves the enabled pending set and offers one interrupt to fetch
// through a valid/ready handshake with frozen cause and source id.
module interrupt_arbiter #(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
    parameter int                 TICK_DIV  = 1,
    parameter int                 SRC_ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          priv,
    input  logic                mstatus_mie,
    input  logic [63:0]         mie,
    input  logic                msip,
    input  logic [NUM_SRC-1:0]  ext_irq,
    input  logic                mtimecmp_we,
    input  logic [63:0]         mtimecmp_wdata,
    input  logic                int_ready,
    output logic                int_valid,
    output logic [3:0]          int_cause,
    output logic [SRC_ID_W-1:0] int_src_id,
    output logic [63:0]         mip,
    output logic [63:0]         mtime,
    output logic [63:0]         mtimecmp
);

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

    state_t               state;
    logic [7:0]           presc;
    logic                 tick;
    logic [63:0]          mtime_q;
    logic                 tmr_pend;
    logic                 msip_pend;
    logic [NUM_SRC-1:0]   ext_prev;
    logic [NUM_SRC-1:0]   ext_pend;
    logic [NUM_SRC-1:0]   ext_pend_next;
    logic [NUM_SRC-1:0]   ext_clr;
    logic [SRC_ID_W-1:0]  sel_id;
    logic [3:0]           sel_cause;
    logic                 gen;
    logic                 ext_ok;
    logic                 sw_ok;
    logic                 tm_ok;
    logic                 any_ok;
    logic                 frozen_ok;
    logic                 withdraw;
    logic                 accept;
    logic                 unused_mie;

    assign unused_mie = ^{mie[63:12], mie[10:8], mie[6:4], mie[2:0]};

    assign tick  = (presc == PRESC_MAX);
    assign mtime = mtime_q;

    // Prescaled machine timer, compare register and the one-cycle-late timer pending flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc    <= '0;
            mtime_q  <= '0;
            mtimecmp <= '1;
            tmr_pend <= 1'b0;
        end else begin
            presc <= tick ? 8'd0 : presc + 8'd1;
            if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
            if (mtimecmp_we) begin
                mtimecmp <= mtimecmp_wdata;
            end
            tmr_pend <= (mtime_q >= mtimecmp);
        end
    end

    // Next external pending set: level sources follow the line, edge sources latch rising edges
    always_comb begin
        ext_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ext_clr[i] = accept && (int_cause == CAUSE_MEI) && (int_src_id == SRC_ID_W'(i));
        end
        ext_pend_next = (EDGE_MASK & ((ext_pend & ~ext_clr) | (ext_irq & ~ext_prev)))
                      | (~EDGE_MASK & ext_irq);
    end

    // Register the sampled external lines and software request
    always_ff @(posedge clk) begin
        if (!reset) begin
            ext_prev  <= '0;
            ext_pend  <= '0;
            msip_pend <= 1'b0;
        end else begin
            ext_prev  <= ext_irq;
            ext_pend  <= ext_pend_next;
            msip_pend <= msip;
        end
    end

    // Enable gating and fixed-priority selection (MEI > MSI > MTI, lowest external index first)
    always_comb begin
        gen       = (priv != 2'd3) | mstatus_mie;
        ext_ok    = (|ext_pend) & mie[11];
        sw_ok     = msip_pend & mie[3];
        tm_ok     = tmr_pend & mie[7];
        any_ok    = ext_ok | sw_ok | tm_ok;
        sel_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (ext_pend[i]) begin
                sel_id = SRC_ID_W'(i);
            end
        end
        if (ext_ok) begin
            sel_cause = CAUSE_MEI;
        end else if (sw_ok) begin
            sel_cause = CAUSE_MSI;
        end else begin
            sel_cause = CAUSE_MTI;
        end
    end

    // Decide whether the frozen offer is still legitimate and whether fetch takes it
    always_comb begin
        frozen_ok = 1'b0;
        case (int_cause)
            CAUSE_MEI: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (int_src_id == SRC_ID_W'(i)) begin
                        frozen_ok = ext_pend[i] & mie[11];
                    end
                end
            end
            CAUSE_MSI: frozen_ok = sw_ok;
            CAUSE_MTI: frozen_ok = tm_ok;
            default:   frozen_ok = 1'b0;
        endcase
        withdraw = !gen || !frozen_ok;
        accept   = (state == OFFER) && int_ready && !withdraw;
    end

    // Offer FSM with registered valid/cause/id; the ACK bubble lets CSR updates settle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            int_valid  <= 1'b0;
            int_cause  <= '0;
            int_src_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gen && any_ok) begin
                        state      <= OFFER;
                        int_valid  <= 1'b1;
                        int_cause  <= sel_cause;
                        int_src_id <= ext_ok ? sel_id : '0;
                    end
                end
                OFFER: begin
                    if (withdraw) begin
                        state     <= IDLE;
                        int_valid <= 1'b0;
                    end else if (int_ready) begin
                        state     <= ACK;
                        int_valid <= 1'b0;
                    end
                end
                ACK: begin
                    state     <= IDLE;
                    int_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    int_valid <= 1'b0;
                end
            endcase
        end
    end

    // Architectural view of the registered pending state
    always_comb begin
        mip     = '0;
        mip[11] = |ext_pend;
        mip[7]  = tmr_pend;
        mip[3]  = msip_pend;
    end

endmodule
